// File: rtl/noc_arb_pkg.sv
// noc_arb_pkg: shared state type and round-robin selection for noc_packet_arbiter
package noc_arb_pkg;

    typedef enum logic {IDLE, LOCKED} arb_state_t;

    function automatic logic [3:0] rr_select(input logic [15:0] valid, input logic [3:0] ptr, input int n);
        logic [3:0] r;
        r = ptr;
        for (int i = n - 1; i >= 0; i--)
            if (valid[(int'(ptr) + i) % n]) r = 4'((int'(ptr) + i) % n);
        return r;
    endfunction

endpackage

// File: rtl/noc_skid_buffer.sv
// noc_skid_buffer: 2-entry output register stage with registered upstream ready
module noc_skid_buffer #(
    parameter int W = 33
) (
    input  logic         clk,
    input  logic         rst,
    input  logic [W-1:0] in_data,
    input  logic         in_valid,
    output logic         in_ready,
    output logic [W-1:0] out_data,
    output logic         out_valid,
    input  logic         out_ready
);
    logic [W-1:0] mem [2];
    logic         wp, rp;
    logic [1:0]   cnt;
    logic         push, pop;

    assign in_ready  = cnt != 2'd2;
    assign out_valid = cnt != 2'd0;
    assign out_data  = mem[rp];
    assign push      = in_valid & in_ready;
    assign pop       = out_valid & out_ready;

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt <= '0;
            wp  <= 1'b0;
            rp  <= 1'b0;
        end else begin
            cnt <= cnt + 2'(push) - 2'(pop);
            if (push) wp <= ~wp;
            if (pop) rp <= ~rp;
        end
    end

    always_ff @(posedge clk)
        if (push) mem[wp] <= in_data;

endmodule

// File: rtl/noc_packet_arbiter.sv
// noc_packet_arbiter: packet-locked round-robin arbiter; NOC_PACKET_ARBITER_OUTREG_EN adds a skid output stage
module noc_packet_arbiter
    import noc_arb_pkg::*;
#(
    parameter int FLIT_WIDTH = 32,
    parameter int NUM_INPUTS = 4
) (
    input  logic                                  clk,
    input  logic                                  rst,
    input  logic [NUM_INPUTS-1:0][FLIT_WIDTH-1:0] in_flit,
    input  logic [NUM_INPUTS-1:0]                 in_last,
    input  logic [NUM_INPUTS-1:0]                 in_valid,
    output logic [NUM_INPUTS-1:0]                 in_ready,
    output logic [FLIT_WIDTH-1:0]                 out_flit,
    output logic                                  out_last,
    output logic                                  out_valid,
    input  logic                                  out_ready,
    output logic [NUM_INPUTS-1:0]                 grant,
    output logic                                  busy
);
    localparam int PW = $clog2(NUM_INPUTS);
    localparam logic [NUM_INPUTS-1:0] ONE = 1;

    arb_state_t      state, state_nxt;
    logic [PW-1:0]   ptr, ptr_nxt, gsel, gsel_nxt, sel, cur;
    logic            owned, c_valid, c_ready, c_last, fire;
    logic [FLIT_WIDTH-1:0] c_flit;

    function automatic logic [PW-1:0] inc(input logic [PW-1:0] i);
        return (i == PW'(NUM_INPUTS - 1)) ? '0 : i + 1'b1;
    endfunction

    assign sel      = PW'(rr_select(16'(in_valid), 4'(ptr), NUM_INPUTS));
    assign cur      = (state == LOCKED) ? gsel : sel;
    assign owned    = (state == LOCKED) || (|in_valid);
    assign c_valid  = (state == LOCKED) ? in_valid[gsel] : |in_valid;
    assign c_flit   = in_flit[cur];
    assign c_last   = in_last[cur];
    assign fire     = c_valid & c_ready;
    assign grant    = owned ? ONE << cur : '0;
    assign in_ready = (owned && c_ready) ? ONE << cur : '0;
    assign busy     = state == LOCKED;

    // Any IDLE-cycle flit that is not a completed single-flit packet locks, so a stalled output never switches source.
    always_comb begin
        state_nxt = state;
        ptr_nxt   = ptr;
        gsel_nxt  = gsel;
        if (state == IDLE) begin
            if (|in_valid) begin
                if (fire && c_last) ptr_nxt = inc(sel);
                else begin
                    state_nxt = LOCKED;
                    gsel_nxt  = sel;
                end
            end
        end else if (fire && c_last) begin
            state_nxt = IDLE;
            ptr_nxt   = inc(gsel);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
            ptr   <= '0;
            gsel  <= '0;
        end else begin
            state <= state_nxt;
            ptr   <= ptr_nxt;
            gsel  <= gsel_nxt;
        end
    end

`ifdef NOC_PACKET_ARBITER_OUTREG_EN
    logic [FLIT_WIDTH:0] sk_out;

    noc_skid_buffer #(.W(FLIT_WIDTH + 1)) u_skid (
        .clk      (clk),
        .rst      (rst),
        .in_data  ({c_last, c_flit}),
        .in_valid (c_valid),
        .in_ready (c_ready),
        .out_data (sk_out),
        .out_valid(out_valid),
        .out_ready(out_ready)
    );

    assign {out_last, out_flit} = sk_out;
`else
    assign c_ready   = out_ready;
    assign out_flit  = c_flit;
    assign out_last  = c_last;
    assign out_valid = c_valid;
`endif

endmodule

// File: tb/tb_noc_packet_arbiter.sv
// tb_noc_packet_arbiter: directed self-checking bench for noc_packet_arbiter (default build)
module tb_noc_packet_arbiter;
    logic            clk = 1'b0;
    logic            rst;
    logic [3:0][31:0] in_flit;
    logic [3:0]      in_last, in_valid, in_ready, grant;
    logic [31:0]     out_flit;
    logic            out_last, out_valid, out_ready, busy;
    int              checks = 0;
    int              failures = 0;

    noc_packet_arbiter #(.FLIT_WIDTH(32), .NUM_INPUTS(4)) dut (
        .clk(clk), .rst(rst), .in_flit(in_flit), .in_last(in_last), .in_valid(in_valid),
        .in_ready(in_ready), .out_flit(out_flit), .out_last(out_last), .out_valid(out_valid),
        .out_ready(out_ready), .grant(grant), .busy(busy)
    );

    always #5 clk = ~clk;

    task automatic clr();
        in_valid = '0;
        in_last  = '0;
        in_flit  = '0;
    endtask

    task automatic step();
        @(negedge clk);
        #1;
    endtask

    task automatic test_reset();
        @(negedge clk);
        rst = 1'b1;
        out_ready = 1'b1;
        clr();
        @(posedge clk);
        @(posedge clk);
        #1;
        checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL reset_out_valid got=%b exp=0", out_valid); end
        checks++; if (grant !== 4'b0000) begin failures++; $display("FAIL reset_grant got=%b exp=0000", grant); end
        checks++; if (busy !== 1'b0) begin failures++; $display("FAIL reset_busy got=%b exp=0", busy); end
        checks++; if (in_ready !== 4'b0000) begin failures++; $display("FAIL reset_in_ready got=%b exp=0000", in_ready); end
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic test_single();
        test_reset();
        in_valid = 4'b0001; in_flit[0] = 32'hA0; in_last = 4'b0000; #1;
        checks++; if (out_valid !== 1'b1 || out_flit !== 32'hA0) begin failures++; $display("FAIL single_f0 got=%b/%h exp=1/a0", out_valid, out_flit); end
        checks++; if (in_ready !== 4'b0001) begin failures++; $display("FAIL single_rdy0 got=%b exp=0001", in_ready); end
        step(); in_flit[0] = 32'hA1; #1;
        checks++; if (out_flit !== 32'hA1 || out_last !== 1'b0) begin failures++; $display("FAIL single_f1 got=%h/%b exp=a1/0", out_flit, out_last); end
        checks++; if (grant !== 4'b0001 || busy !== 1'b1) begin failures++; $display("FAIL single_lock1 got=%b/%b exp=0001/1", grant, busy); end
        step(); in_flit[0] = 32'hA2; in_last[0] = 1'b1; #1;
        checks++; if (out_flit !== 32'hA2 || out_last !== 1'b1) begin failures++; $display("FAIL single_f2 got=%h/%b exp=a2/1", out_flit, out_last); end
        checks++; if (grant !== 4'b0001) begin failures++; $display("FAIL single_lock2 got=%b exp=0001", grant); end
        step(); in_valid = 4'b0011; in_last = 4'b0011; in_flit[0] = 32'hB0; in_flit[1] = 32'hB1; #1;
        checks++; if (busy !== 1'b0) begin failures++; $display("FAIL single_busy_drop got=%b exp=0", busy); end
        checks++; if (out_flit !== 32'hB1 || in_ready !== 4'b0010) begin failures++; $display("FAIL single_ptr1 got=%h/%b exp=b1/0010", out_flit, in_ready); end
        step(); clr();
    endtask

    task automatic test_contention();
        test_reset();
        in_valid = 4'b0101; in_flit[0] = 32'hC0; in_flit[2] = 32'hD0; #1;
        checks++; if (out_flit !== 32'hC0 || in_ready !== 4'b0001) begin failures++; $display("FAIL cont_c0 got=%h/%b exp=c0/0001", out_flit, in_ready); end
        step(); in_flit[0] = 32'hC1; in_last[0] = 1'b1; #1;
        checks++; if (out_flit !== 32'hC1 || out_last !== 1'b1 || grant !== 4'b0001) begin failures++; $display("FAIL cont_c1 got=%h/%b/%b exp=c1/1/0001", out_flit, out_last, grant); end
        step(); in_valid = 4'b0100; in_last = 4'b0000; #1;
        checks++; if (out_flit !== 32'hD0 || in_ready !== 4'b0100) begin failures++; $display("FAIL cont_d0 got=%h/%b exp=d0/0100", out_flit, in_ready); end
        step(); in_flit[2] = 32'hD1; in_last[2] = 1'b1; #1;
        checks++; if (out_flit !== 32'hD1 || grant !== 4'b0100 || busy !== 1'b1) begin failures++; $display("FAIL cont_d1 got=%h/%b/%b exp=d1/0100/1", out_flit, grant, busy); end
        step(); in_valid = 4'b1001; in_last = 4'b1001; in_flit[0] = 32'hE0; in_flit[3] = 32'hE3; #1;
        checks++; if (out_flit !== 32'hE3 || in_ready !== 4'b1000) begin failures++; $display("FAIL cont_ptr3 got=%h/%b exp=e3/1000", out_flit, in_ready); end
        step(); in_flit[3] = 32'hE4; #1;
        checks++; if (out_flit !== 32'hE0 || in_ready !== 4'b0001) begin failures++; $display("FAIL cont_wrap got=%h/%b exp=e0/0001", out_flit, in_ready); end
        step(); clr();
    endtask

    task automatic test_stall();
        test_reset();
        out_ready = 1'b0;
        in_valid = 4'b0010; in_last = 4'b0011; in_flit[1] = 32'hF1; in_flit[0] = 32'hF0; #1;
        checks++; if (out_valid !== 1'b1 || out_flit !== 32'hF1 || in_ready !== 4'b0000) begin failures++; $display("FAIL stall_first got=%b/%h/%b exp=1/f1/0000", out_valid, out_flit, in_ready); end
        for (int c = 1; c < 5; c++) begin
            step();
            if (c == 2) begin in_valid = 4'b0011; #1; end
            checks++; if (out_flit !== 32'hF1 || grant !== 4'b0010 || in_ready !== 4'b0000) begin failures++; $display("FAIL stall_hold%0d got=%h/%b/%b exp=f1/0010/0000", c, out_flit, grant, in_ready); end
        end
        step(); out_ready = 1'b1; #1;
        checks++; if (out_flit !== 32'hF1 || in_ready !== 4'b0010) begin failures++; $display("FAIL stall_accept got=%h/%b exp=f1/0010", out_flit, in_ready); end
        step(); in_valid = 4'b0001; #1;
        checks++; if (out_flit !== 32'hF0 || in_ready !== 4'b0001) begin failures++; $display("FAIL stall_next got=%h/%b exp=f0/0001", out_flit, in_ready); end
        step(); clr();
    endtask

    task automatic test_round_robin();
        test_reset();
        in_valid = 4'b1111; in_last = 4'b1111;
        for (int i = 0; i < 4; i++) in_flit[i] = 32'h100 + i;
        #1;
        for (int c = 0; c < 12; c++) begin
            checks++; if (out_valid !== 1'b1 || out_flit !== 32'h100 + (c % 4)) begin failures++; $display("FAIL rr_cycle%0d got=%b/%h exp=1/%h", c, out_valid, out_flit, 32'h100 + (c % 4)); end
            checks++; if (in_ready !== 4'b0001 << (c % 4) || busy !== 1'b0) begin failures++; $display("FAIL rr_ready%0d got=%b/%b exp=%b/0", c, in_ready, busy, 4'b0001 << (c % 4)); end
            step();
        end
        clr();
    endtask

    task automatic test_gap();
        test_reset();
        in_valid = 4'b1000; in_flit[3] = 32'h60; in_flit[0] = 32'h70; in_last = 4'b0001; #1;
        checks++; if (out_flit !== 32'h60 || in_ready !== 4'b1000) begin failures++; $display("FAIL gap_first got=%h/%b exp=60/1000", out_flit, in_ready); end
        for (int c = 0; c < 3; c++) begin
            step(); in_valid = 4'b0001; #1;
            checks++; if (out_valid !== 1'b0 || grant !== 4'b1000 || busy !== 1'b1 || in_ready[0] !== 1'b0) begin failures++; $display("FAIL gap_hold%0d got=%b/%b/%b/%b exp=0/1000/1/0", c, out_valid, grant, busy, in_ready[0]); end
        end
        step(); in_valid = 4'b1001; in_flit[3] = 32'h61; in_last = 4'b1001; #1;
        checks++; if (out_flit !== 32'h61 || out_last !== 1'b1 || in_ready !== 4'b1000) begin failures++; $display("FAIL gap_last got=%h/%b/%b exp=61/1/1000", out_flit, out_last, in_ready); end
        step(); in_valid = 4'b0001; #1;
        checks++; if (out_flit !== 32'h70 || busy !== 1'b0) begin failures++; $display("FAIL gap_after got=%h/%b exp=70/0", out_flit, busy); end
        step(); clr();
    endtask

    task automatic test_reset_mid();
        test_reset();
        in_valid = 4'b0010; in_flit[1] = 32'h90; #1;
        step(); in_flit[1] = 32'h91; rst = 1'b1; #1;
        step(); clr(); #1;
        checks++; if (out_valid !== 1'b0 || grant !== 4'b0000 || busy !== 1'b0) begin failures++; $display("FAIL rstmid_clear got=%b/%b/%b exp=0/0000/0", out_valid, grant, busy); end
        step(); rst = 1'b0;
        in_valid = 4'b0011; in_last = 4'b0011; in_flit[0] = 32'h80; in_flit[1] = 32'h81; #1;
        checks++; if (out_flit !== 32'h80 || in_ready !== 4'b0001) begin failures++; $display("FAIL rstmid_first got=%h/%b exp=80/0001", out_flit, in_ready); end
        step(); clr();
    endtask

    initial begin
        rst = 1'b1;
        out_ready = 1'b1;
        clr();
        test_single();
        test_contention();
        test_stall();
        test_round_robin();
        test_gap();
        test_reset_mid();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/noc_packet_arbiter.md
Name: noc_packet_arbiter

Overview:
Packet-level round-robin arbiter that shares one NoC output channel among NUM_INPUTS flit sources, e.g. the NA message-passing and DMA engines inside a compute tile feeding one physical channel of noc_out_flit/last/valid/ready. A grant is locked from the first flit of a packet until its last flit, so packets are never interleaved on the output. Sits between the tile-internal packet sources and the tile's NoC output port.

Parameters:
FLIT_WIDTH, 32, width of one flit in bits.
NUM_INPUTS, 4, number of requesters; legal range 2..16.

Ports:
clk  input  1  system clock; all logic on rising edge.
rst  input  1  synchronous, active-high reset.
in_flit  input  NUM_INPUTS x FLIT_WIDTH  flit per requester, packed [NUM_INPUTS-1:0][FLIT_WIDTH-1:0].
in_last  input  NUM_INPUTS  last-flit marker per requester.
in_valid  input  NUM_INPUTS  flit valid per requester.
in_ready  output  NUM_INPUTS  flit accepted when valid & ready.
out_flit  output  FLIT_WIDTH  arbitrated flit.
out_last  output  1  last-flit marker of the forwarded flit.
out_valid  output  1  output flit valid.
out_ready  input  1  downstream ready.
grant  output  NUM_INPUTS  one-hot of the input currently owning the channel; 0 when idle.
busy  output  1  high while in LOCKED.

Behaviour:
- Reset: state IDLE, round-robin pointer ptr=0, grant=0, busy=0, out_valid=0, in_ready=0. Reset mid-packet discards the lock without emitting anything; upstream is also in reset.
- Handshake: valid/ready; transfer when valid & ready on the same cycle. Sources hold flit, last and valid stable until accepted. The arbiter never drops or duplicates a flit.
- IDLE:
  - Combinational selection: sel = first index with in_valid set, searching ptr, ptr+1 … wrapping modulo NUM_INPUTS.
  - If any input is valid: out_* = in_*[sel], in_ready[sel] = out_ready, other in_ready = 0. This gives zero-cycle latency and no bubble.
  - Accepted flit with in_last=1 (single-flit packet): stay IDLE, ptr = sel+1 mod N.
  - Otherwise (multi-flit packet accepted, or out_ready=0): go LOCKED with gsel=sel registered. This keeps out_* stable while stalled, even if a higher-priority input asserts valid afterwards.
  - No valid input: out_valid=0, grant=0.
- LOCKED:
  - out_* = in_*[gsel], in_ready[gsel] = out_ready, others 0, grant = onehot(gsel), busy=1.
  - Accepted flit with last=1: go IDLE, ptr = gsel+1 mod N. The next packet can be granted the following cycle, so there is exactly one arbitration cycle overlap and no idle gap is required.
  - Gaps where in_valid[gsel]=0 mid-packet are legal; the lock is held and out_valid=0.
- Fairness: each requester waits at most NUM_INPUTS-1 packets.
- ptr wrap: NUM_INPUTS-1 advances to 0; NUM_INPUTS need not be a power of two.

Optional Feature:
- Macro: NOC_PACKET_ARBITER_OUTREG_EN.
- Defined: inserts a 2-entry skid register stage on out_flit/out_last/out_valid.
  - Latency is 1 cycle; full throughput is kept.
  - The internal ready towards the arbiter core is registered (high while the skid buffer has a free entry), which breaks the out_ready → in_ready combinational path.
  - Arbitration and lock rules are unchanged and apply at the core/skid interface.
  - out_valid resets to 0 and the buffer resets to empty.
- Undefined: purely combinational datapath as described above, with 0-cycle latency.

Decomposition:
- Shared package noc_arb_pkg: enum arb_state_t {IDLE, LOCKED}; function rr_select(valid, ptr) returning the index.
- Sub-module noc_skid_buffer (FLIT_WIDTH+1 bits wide), instantiated only under NOC_PACKET_ARBITER_OUTREG_EN.

Test Plan:
- Single source: in0 sends a 3-flit packet 0xA0,0xA1,0xA2 (last on 0xA2) with out_ready=1 → out shows the same 3 flits on consecutive cycles; grant=0001 during the packet; busy drops after 0xA2; ptr=1.
- Contention: in0 and in2 both valid with 2-flit packets after reset → in0 packet fully first, then in2; no interleave; ptr ends at 3.
- Stall stability: in1 valid with out_ready=0 for 5 cycles, then in0 asserts valid → out_flit stays in1's flit and grant=0010 until acceptance.
- Round-robin fairness: all 4 inputs continuously send 1-flit packets → output order 0,1,2,3,0,1,… with no bubbles over 12 cycles.
- Mid-packet source gap: in3 sends flit, drops valid for 3 cycles, sends last → lock held and in0 never granted during the gap.
- Reset mid-packet: assert rst during in1 flit 2 of 4 → next cycle out_valid=0, grant=0; after release, in0 is granted first.
